// File: rtl/fcmp_pipe.sv
// Two-stage binary32 compare / min-max pipeline (feq, flt, fle, fmin, fmax), 2-cycle latency, valid/ready with flush.
// fmin/fmax datapath exists only when FCMP_MINMAX_EN is defined; otherwise those encodings are reported illegal.
module fcmp_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_nv,
    output logic             out_illegal
);

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic [31:0]      s1_x_q, s1_x_d;
    logic [31:0]      s1_y_q, s1_y_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             nv_q, nv_d;
    logic             ill_q, ill_d;

    logic        s1_adv, s2_adv, accept;
    logic        x_nan, y_nan, x_snan, y_snan, any_nan, any_snan, both_zero;
    logic        ord_lt, cmp_eq, cmp_lt;
    logic [31:0] res_c;
    logic        nv_c, ill_c;

    assign x_nan     = (&s1_x_q[30:23]) && (|s1_x_q[22:0]);
    assign y_nan     = (&s1_y_q[30:23]) && (|s1_y_q[22:0]);
    assign x_snan    = x_nan && !s1_x_q[22];
    assign y_snan    = y_nan && !s1_y_q[22];
    assign any_nan   = x_nan || y_nan;
    assign any_snan  = x_snan || y_snan;
    assign both_zero = (s1_x_q[30:0] == 31'd0) && (s1_y_q[30:0] == 31'd0);

    // Total order on non-NaN values where -0 sorts below +0; compares mask the zero case separately.
    assign ord_lt = (s1_x_q[31] != s1_y_q[31]) ? s1_x_q[31] :
                    (s1_x_q[31] ? (s1_x_q[30:0] > s1_y_q[30:0]) : (s1_x_q[30:0] < s1_y_q[30:0]));
    assign cmp_eq = !any_nan && ((s1_x_q == s1_y_q) || both_zero);
    assign cmp_lt = !any_nan && !both_zero && ord_lt;

    always_comb begin
        res_c = 32'd0;
        nv_c  = 1'b0;
        ill_c = 1'b0;
        case (s1_op_q)
            3'b000: begin res_c = {31'd0, cmp_eq};           nv_c = any_snan; end
            3'b001: begin res_c = {31'd0, cmp_lt};           nv_c = any_nan;  end
            3'b010: begin res_c = {31'd0, cmp_lt || cmp_eq}; nv_c = any_nan;  end
`ifdef FCMP_MINMAX_EN
            3'b011, 3'b100: begin
                nv_c = any_snan;
                if (x_nan && y_nan)
                    res_c = 32'h7FC0_0000;
                else if (x_nan)
                    res_c = s1_y_q;
                else if (y_nan)
                    res_c = s1_x_q;
                else if (ord_lt == (s1_op_q == 3'b011))
                    res_c = s1_x_q;
                else
                    res_c = s1_y_q;
            end
`endif
            default: ill_c = 1'b1;
        endcase
    end

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        tag_d      = tag_q;
        nv_d       = nv_q;
        ill_d      = ill_q;
        if (s1_adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_op_d  = in_op;
                s1_x_d   = in_x;
                s1_y_d   = in_y;
                s1_tag_d = in_tag;
            end
        end
        // Output fields only load with a real op so a stalled or idle result stays put.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d = res_c;
                tag_d = s1_tag_q;
                nv_d  = nv_c;
                ill_d = ill_c;
            end
        end
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 3'd0;
            s1_x_q     <= 32'd0;
            s1_y_q     <= 32'd0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= 32'd0;
            tag_q      <= '0;
            nv_q       <= 1'b0;
            ill_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            tag_q      <= tag_d;
            nv_q       <= nv_d;
            ill_q      <= ill_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_result  = res_q;
    assign out_tag     = tag_q;
    assign out_nv      = nv_q;
    assign out_illegal = ill_q;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Bench for fcmp_pipe: scoreboard of expected results pushed at input handshake, popped at output handshake,
// plus directed scenario tasks. Build with FCMP_MINMAX_EN defined or not; expectations follow the macro.
module tb_fcmp_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [31:0] in_x = 32'd0;
    logic [31:0] in_y = 32'd0;
    logic [4:0]  in_tag = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_nv;
    logic        out_illegal;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        nv;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        logic        nv;
        logic        ill;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t dir_tab[12];
    logic [31:0] pool[15];

    fcmp_pipe #(.TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_nv(out_nv), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Unsigned key that is monotonic in the IEEE total order of non-NaN values (-0 below +0).
    function automatic logic [31:0] okey(input logic [31:0] v);
        return v[31] ? ~v : {1'b1, v[30:0]};
    endfunction

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                   input logic [4:0] tag);
        exp_t e;
        logic xn, yn, xs, ys;
        logic [31:0] xz, yz;
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        xs = xn && (x[22] == 1'b0);
        ys = yn && (y[22] == 1'b0);
        xz = (x[30:0] == 31'd0) ? 32'd0 : x;
        yz = (y[30:0] == 31'd0) ? 32'd0 : y;
        e = '{res: 32'd0, tag: tag, nv: 1'b0, ill: 1'b0};
        case (op)
            3'd0: begin e.res = {31'd0, !(xn || yn) && (xz == yz)}; e.nv = xs || ys; end
            3'd1: begin e.res = {31'd0, !(xn || yn) && (okey(xz) < okey(yz))}; e.nv = xn || yn; end
            3'd2: begin e.res = {31'd0, !(xn || yn) && (okey(xz) <= okey(yz))}; e.nv = xn || yn; end
`ifdef FCMP_MINMAX_EN
            3'd3, 3'd4: begin
                e.nv = xs || ys;
                if (xn && yn)      e.res = 32'h7FC0_0000;
                else if (xn)       e.res = y;
                else if (yn)       e.res = x;
                else if (op == 3'd3) e.res = (okey(x) <= okey(y)) ? x : y;
                else               e.res = (okey(x) >= okey(y)) ? x : y;
            end
`endif
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Scoreboard: pop/compare on output handshake, then push on input handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected_output: got res=%h tag=%0d, expected no output", out_result, out_tag);
                end else begin
                    mon_e = sb.pop_front();
                    if ({out_result, out_tag, out_nv, out_illegal} !== {mon_e.res, mon_e.tag, mon_e.nv, mon_e.ill}) begin
                        miscompares++;
                        $display("FAIL sb_result: got res=%h tag=%0d nv=%b ill=%b, expected res=%h tag=%0d nv=%b ill=%b",
                                 out_result, out_tag, out_nv, out_illegal, mon_e.res, mon_e.tag, mon_e.nv, mon_e.ill);
                    end
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(in_op, in_x, in_y, in_tag));
        end
    end

    // Offers one op on an idle pipe; returns its outputs and the cycles from accept to out_valid.
    task automatic send_and_wait(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                 input logic [4:0] tag, output logic [31:0] res, output logic nv,
                                 output logic ill, output logic [4:0] otag, output int lat);
        int n;
        @(posedge clk) #1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = op; in_x = x; in_y = y; in_tag = tag;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk) #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        res = out_result; nv = out_nv; ill = out_illegal; otag = out_tag;
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async_out_valid: got %b, expected 0", out_valid);
        end
        @(posedge clk); @(posedge clk) #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready, out_result, out_tag, out_nv, out_illegal} !== {1'b0, 1'b1, 32'd0, 5'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b rdy=%b res=%h tag=%0d nv=%b ill=%b, expected 0 1 0 0 0 0",
                     out_valid, in_ready, out_result, out_tag, out_nv, out_illegal);
        end
    endtask

    task automatic test_flt_latency;
        logic [31:0] r; logic nv, ill; logic [4:0] t; int lat;
        send_and_wait(3'd1, 32'hBF80_0000, 32'h3F80_0000, 5'd7, r, nv, ill, t, lat);
        vectors++;
        if (lat !== 2 || r !== 32'd1 || nv !== 1'b0 || t !== 5'd7) begin
            miscompares++;
            $display("FAIL flt_latency: got lat=%0d res=%h nv=%b tag=%0d, expected lat=2 res=1 nv=0 tag=7", lat, r, nv, t);
        end
    endtask

    task automatic test_compares;
        logic [31:0] r; logic nv, ill; logic [4:0] t; int lat;
        dir_tab[0]  = '{3'd0, 32'h8000_0000, 32'h0000_0000, 32'd1, 1'b0, 1'b0};
        dir_tab[1]  = '{3'd2, 32'h7FC0_0000, 32'h3F80_0000, 32'd0, 1'b1, 1'b0};
        dir_tab[2]  = '{3'd0, 32'h7F80_0001, 32'h3F80_0000, 32'd0, 1'b1, 1'b0};
        dir_tab[3]  = '{3'd0, 32'h7FC0_0000, 32'h7FC0_0000, 32'd0, 1'b0, 1'b0};
        dir_tab[4]  = '{3'd1, 32'h0000_0000, 32'h8000_0000, 32'd0, 1'b0, 1'b0};
        dir_tab[5]  = '{3'd2, 32'h8000_0000, 32'h0000_0000, 32'd1, 1'b0, 1'b0};
        dir_tab[6]  = '{3'd1, 32'hC000_0000, 32'hBF80_0000, 32'd1, 1'b0, 1'b0};
        dir_tab[7]  = '{3'd1, 32'hBF80_0000, 32'hC000_0000, 32'd0, 1'b0, 1'b0};
        dir_tab[8]  = '{3'd2, 32'h3F80_0000, 32'h3F80_0000, 32'd1, 1'b0, 1'b0};
        dir_tab[9]  = '{3'd1, 32'hFF80_0000, 32'h7F80_0000, 32'd1, 1'b0, 1'b0};
        dir_tab[10] = '{3'd5, 32'h3F80_0000, 32'h4000_0000, 32'd0, 1'b0, 1'b1};
        dir_tab[11] = '{3'd7, 32'h7F80_0001, 32'h7F80_0001, 32'd0, 1'b0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            send_and_wait(dir_tab[i].op, dir_tab[i].x, dir_tab[i].y, 5'(i), r, nv, ill, t, lat);
            vectors++;
            if ({r, nv, ill} !== {dir_tab[i].res, dir_tab[i].nv, dir_tab[i].ill}) begin
                miscompares++;
                $display("FAIL compare_vec%0d: got res=%h nv=%b ill=%b, expected res=%h nv=%b ill=%b",
                         i, r, nv, ill, dir_tab[i].res, dir_tab[i].nv, dir_tab[i].ill);
            end
        end
    endtask

    task automatic test_minmax;
        logic [31:0] r; logic nv, ill; logic [4:0] t; int lat;
        logic [33:0] exp0, exp1;
`ifdef FCMP_MINMAX_EN
        exp0 = {32'h4000_0000, 1'b1, 1'b0};
        exp1 = {32'h0000_0000, 1'b0, 1'b0};
`else
        exp0 = {32'd0, 1'b0, 1'b1};
        exp1 = {32'd0, 1'b0, 1'b1};
`endif
        send_and_wait(3'd3, 32'h7F80_0001, 32'h4000_0000, 5'd20, r, nv, ill, t, lat);
        vectors++;
        if ({r, nv, ill} !== exp0) begin
            miscompares++;
            $display("FAIL fmin_snan: got res=%h nv=%b ill=%b, expected %h", r, nv, ill, exp0);
        end
        send_and_wait(3'd4, 32'h8000_0000, 32'h0000_0000, 5'd21, r, nv, ill, t, lat);
        vectors++;
        if ({r, nv, ill} !== exp1) begin
            miscompares++;
            $display("FAIL fmax_zero: got res=%h nv=%b ill=%b, expected %h", r, nv, ill, exp1);
        end
    endtask

    task automatic test_back_to_back;
        int sent = 0;
        int acc_low = 0;
        int cyc = 0;
        while (sent < 8 && cyc < 100) begin
            @(posedge clk) #1;
            out_ready = (cyc >= 3);
            in_valid = 1'b1; in_op = 3'(sent % 3);
            in_x = pool[sent]; in_y = pool[14 - sent]; in_tag = 5'(sent + 1);
            @(negedge clk);
            if (cyc == 2) begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_stall_ready: got in_ready=%b, expected 0", in_ready);
                end
            end
            if (in_ready) begin
                sent++;
                if (cyc < 3) acc_low++;
            end
            cyc++;
        end
        @(posedge clk) #1;
        in_valid = 1'b0; out_ready = 1'b1;
        vectors++;
        if (acc_low !== 2) begin
            miscompares++;
            $display("FAIL b2b_accepts: got %0d accepts while stalled, expected 2", acc_low);
        end
        repeat (4) @(negedge clk);
        #1;
        vectors++;
        if (sb.size() !== 0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: got %0d pending, out_valid=%b, expected 0 and 0", sb.size(), out_valid);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk) #1;
            in_valid = 1'b1; in_op = 3'd1; in_x = 32'h3F80_0000; in_y = 32'h4000_0000; in_tag = 5'(10 + i);
        end
        @(posedge clk) #1;
        in_tag = 5'd12; flush = 1'b1;
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL flush_setup: got out_valid=%b in_ready=%b, expected 1 0", out_valid, in_ready);
        end
        @(posedge clk) #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_out_valid_c%0d: got %b, expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_reset_midstream;
        logic [31:0] r; logic nv, ill; logic [4:0] t; int lat;
        out_ready = 1'b1;
        @(posedge clk) #1;
        in_valid = 1'b1; in_op = 3'd0; in_x = 32'd5; in_y = 32'd5; in_tag = 5'd3;
        @(posedge clk) #1;
        in_tag = 5'd4;
        @(posedge clk) #1;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_setup: got out_valid=%b, expected 1", out_valid);
        end
        rst = 1'b1;
        sb.delete();
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_async: got out_valid=%b, expected 0", out_valid);
        end
        @(posedge clk); @(posedge clk) #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rst_mid_release: got out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
        send_and_wait(3'd2, 32'h4000_0000, 32'h3F80_0000, 5'd9, r, nv, ill, t, lat);
        vectors++;
        if (lat !== 2 || r !== 32'd0 || t !== 5'd9) begin
            miscompares++;
            $display("FAIL rst_mid_first_op: got lat=%0d res=%h tag=%0d, expected lat=2 res=0 tag=9", lat, r, t);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk) #1;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_op = 3'($urandom_range(0, 7));
            in_x = ($urandom_range(0, 4) == 0) ? $urandom : pool[$urandom_range(0, 14)];
            in_y = ($urandom_range(0, 4) == 0) ? $urandom : pool[$urandom_range(0, 14)];
            in_tag = 5'(i);
        end
        @(posedge clk) #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        vectors++;
        if (sb.size() !== 0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL random_drain: got %0d pending, out_valid=%b, expected 0 and 0", sb.size(), out_valid);
        end
    endtask

    initial begin
        pool = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000,
                 32'hC000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7F80_0001,
                 32'hFFC0_0000, 32'h0000_0001, 32'h8000_0001, 32'h3F80_0001, 32'h7F7F_FFFF};
        test_reset();
        test_flt_latency();
        test_compares();
        test_minmax();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
